mul_accumulator: RTL and testbench
==================================

// Module: mul_accumulator
// PURPOSE
//  Downstream consumer of the 32x32 signed Wallace-tree multiplier.
//  Accumulates a programmed number of 64-bit signed products into a saturating
//  64-bit accumulator, then presents the sum through a valid/ready result port.
//  Upstream port: the multiplier product (C), qualified by prod_valid/prod_ready.
//  Turns the combinational multiplier into a multiply-accumulate (dot-product) engine.
// PARAMETERS
//  PROD_W   64  width of signed product input (multiplier C output)
//  ACC_W    64  width of signed accumulator / result; ACC_W >= PROD_W
//  CNT_W    8   width of term count; max terms per job = 2**CNT_W-1
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst         in   1        asynchronous, active-high reset
//  start       in   1        begin job; sampled only in IDLE
//  len         in   CNT_W    number of products in job; sampled with start
//  prod        in   PROD_W   signed product from multiplier
//  prod_valid  in   1        prod holds a valid term
//  prod_ready  out  1        block accepts prod this cycle
//  acc_out     out  ACC_W    signed accumulated result
//  acc_valid   out  1        acc_out holds a finished result
//  acc_ready   in   1        consumer takes result
//  overflow    out  1        sticky: saturation occurred during current job
//  busy        out  1        state != IDLE
//  count       out  CNT_W    terms accepted so far in current job
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, acc_out=0, count=0, overflow=0,
//    acc_valid=0, prod_ready=0, busy=0. Reset mid-job abandons the job; no result emitted.
//  - FSM states IDLE, ACCUM, DONE.
//    IDLE: start=1 and len!=0 -> ACCUM; acc_out<=0, count<=0, overflow<=0,
//      len latched. start=1 and len==0 -> DONE with acc_out=0, overflow=0.
//    ACCUM: prod_ready=1. Accept when prod_valid&&prod_ready. On each accept,
//      acc_out <= sat(acc_out + sext(prod)) and count <= count+1.
//      Accept with count==len_latched-1 -> DONE.
//    DONE: acc_valid=1, prod_ready=0, acc_out/overflow/count held stable.
//      acc_ready=1 -> IDLE next cycle; acc_valid drops in that cycle.
//  - prod_ready is a registered function of state only. It is never
//    combinationally dependent on prod_valid.
//  - Latency: acc_valid rises the cycle after the final accept.
//    Back-to-back accepts are permitted every cycle.
//  - start while busy is ignored; len is not re-sampled.
//  - Arithmetic: two's-complement, prod sign-extended to ACC_W.
//    Signed overflow occurs when the operands share a sign and the result
//    sign differs. On overflow, clamp to 2**(ACC_W-1)-1 (positive) or
//    -2**(ACC_W-1) (negative) and set overflow=1 (sticky until next start).
//    Accumulation continues from the clamped value.
//  - Results stay in IDLE until a new start: acc_out, overflow and count keep the
//    last job's values and acc_valid=0.
// TESTING
//  1. start,len=3; prod=1296,-1296,1296 on consecutive cycles -> acc_out=1296,
//     acc_valid=1 one cycle after 3rd accept, overflow=0, count=3.
//  2. start,len=0 -> next cycle DONE, acc_valid=1, acc_out=0; acc_ready=1 -> IDLE.
//  3. len=2; prod=64'h7FFF_FFFF_FFFF_FFFF then 1 -> acc_out=64'h7FFF_FFFF_FFFF_FFFF,
//     overflow=1. Mirror case: 64'h8000_0000_0000_0000 then -1 -> 64'h8000_..._0000.
//  4. len=4; prod_valid toggled 1,0,0,1,1,0,1 with prod=-1296 -> exactly 4 accepts,
//     acc_out=-5184. acc_ready held 0 for 5 cycles -> acc_valid and acc_out stable.
//     prod_ready=0 in DONE; start pulses during DONE are ignored.
//  5. len=5; assert rst after 2 accepts -> same cycle all outputs 0, IDLE.
//     New start,len=1, prod=0 -> acc_out=0, overflow=0.

Source files
------------

// File: rtl/mul_accumulator.sv
// Multiply-accumulate back end: sums a programmed number of signed products into a saturating accumulator.
// Latency: acc_valid rises the cycle after the final accepted product; a len==0 job completes the cycle after start.
// Backpressure: prod_ready is registered from state only; the result is held in DONE until acc_ready.
module mul_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 64,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturation rails of the signed accumulator.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] len_q;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W-1:0]  sum_raw;
  logic signed [ACC_W-1:0]  sum_sat;
  logic                     sum_ovf;
  logic                     take;
  logic                     last_term;

  assign prod_s = prod;
  assign acc_s  = acc_out;

  // Sign-extend the product to accumulator width, add, and clamp on signed overflow.
  // Overflow can only happen when both operands share a sign and the raw sum flips it;
  // the clamp direction is then the operands' common sign.
  always_comb begin
    prod_ext = ACC_W'(prod_s);
    sum_raw  = acc_s + prod_ext;
    sum_ovf  = (acc_s[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_raw[ACC_W-1] != acc_s[ACC_W-1]);
    if (!sum_ovf) begin
      sum_sat = sum_raw;
    end else if (acc_s[ACC_W-1]) begin
      sum_sat = SAT_MIN;
    end else begin
      sum_sat = SAT_MAX;
    end
  end

  // A transfer happens on the handshake; the job ends when the len-th term is taken.
  assign take      = prod_valid && prod_ready;
  assign last_term = (count == (len_q - CNT_W'(1)));

  // Job sequencer: all outputs are registered and updated alongside the state.
  // prod_ready/acc_valid/busy are set from the state being entered, so they never
  // depend combinationally on prod_valid or acc_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      acc_out    <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      acc_valid  <= 1'b0;
      prod_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Previous job's acc_out/overflow/count stay visible until a new start.
          if (start) begin
            len_q    <= len;
            acc_out  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (len != '0) begin
              state      <= ACCUM;
              prod_ready <= 1'b1;
            end else begin
              // Empty job: present a zero result straight away.
              state     <= DONE;
              acc_valid <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (take) begin
            acc_out  <= sum_sat;
            overflow <= overflow | sum_ovf;
            count    <= count + CNT_W'(1);
            if (last_term) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              acc_valid  <= 1'b1;
            end
          end
        end

        DONE: begin
          // Result held stable; start is ignored until the consumer takes it.
          if (acc_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          acc_valid  <= 1'b0;
          prod_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Testbench for mul_accumulator: directed corner jobs plus randomized jobs.
// Expected results come from a wide-integer saturating sum over the accepted terms.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_mul_accumulator;

  localparam int PROD_W = 64;
  localparam int ACC_W  = 64;
  localparam int CNT_W  = 8;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready;
  logic              overflow;
  logic              busy;
  logic [CNT_W-1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PROD_W-1:0] stim_q[$];   // terms offered for the next job, in order
  logic [PROD_W-1:0] acc_q[$];    // terms actually accepted by the DUT
  bit                vpat_q[$];   // optional prod_valid pattern; random when empty

  logic [ACC_W-1:0] exp_acc;
  logic             exp_ovf;

  mul_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .prod      (prod),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .overflow  (overflow),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact sum in a wider integer, clamped to the rails after every term.
  task automatic model();
    logic signed [ACC_W+1:0] s;
    logic signed [ACC_W+1:0] term;
    logic signed [ACC_W+1:0] wmax;
    logic signed [ACC_W+1:0] wmin;
    wmax    = ACC_MAX;
    wmin    = ACC_MIN;
    s       = '0;
    exp_ovf = 1'b0;
    foreach (acc_q[i]) begin
      term = $signed(acc_q[i]);
      s    = s + term;
      if (s > wmax) begin
        s       = wmax;
        exp_ovf = 1'b1;
      end else if (s < wmin) begin
        s       = wmin;
        exp_ovf = 1'b1;
      end
    end
    exp_acc = s[ACC_W-1:0];
  endtask

  function automatic logic [PROD_W-1:0] rand_prod();
    logic signed [PROD_W-1:0] t;
    case ($urandom_range(0, 3))
      0: t = {$urandom, $urandom};
      1: begin
        t = $urandom_range(0, 4000);
        t = t - 2000;
      end
      2: t = ACC_MAX - $urandom_range(0, 3);
      default: t = ACC_MIN + $urandom_range(0, 3);
    endcase
    return t;
  endfunction

  // Start a job of n terms taken from stim_q and run it until the result is presented.
  task automatic run_job(input string tag, input int n);
    int idx;
    int budget;
    bit v;
    bit will_take;
    acc_q.delete();
    idx    = 0;
    budget = 1000;
    start  = 1'b1;
    len    = CNT_W'(n);
    step();
    start  = 1'b0;
    len    = CNT_W'($urandom);
    check({tag, "_busy"}, busy, 1);
    while (acc_q.size() < n && budget > 0) begin
      check({tag, "_rdy_accum"}, prod_ready, 1);
      if (vpat_q.size() > 0) v = vpat_q.pop_front();
      else v = ($urandom_range(0, 9) < 7);
      prod_valid = v;
      prod       = v ? stim_q[idx] : {$urandom, $urandom};
      will_take  = v && prod_ready;
      step();
      if (will_take) begin
        acc_q.push_back(stim_q[idx]);
        idx++;
        check({tag, "_count"}, count, idx);
      end
      budget--;
    end
    prod_valid = 1'b0;
    if (budget == 0) check({tag, "_timeout_accepts"}, acc_q.size(), n);
    model();
    // One cycle after the final accept (or after start for an empty job).
    check({tag, "_valid"}, acc_valid, 1);
    check({tag, "_acc"}, acc_out, exp_acc);
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_count_final"}, count, n);
    check({tag, "_rdy_done"}, prod_ready, 0);
  endtask

  // Hold the result for 'hold' cycles (optionally poking start), then take it.
  task automatic drain(input string tag, input int n, input int hold, input bit poke);
    acc_ready = 1'b0;
    repeat (hold) begin
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      len   = CNT_W'($urandom);
      step();
      check({tag, "_hold_valid"}, acc_valid, 1);
      check({tag, "_hold_acc"}, acc_out, exp_acc);
      check({tag, "_hold_rdy"}, prod_ready, 0);
      check({tag, "_hold_count"}, count, n);
    end
    start     = 1'b0;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    check({tag, "_idle_valid"}, acc_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    step();
    check({tag, "_idle_acc"}, acc_out, exp_acc);
    check({tag, "_idle_ovf"}, overflow, exp_ovf);
    check({tag, "_idle_count"}, count, n);
    check({tag, "_idle_valid2"}, acc_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    len        = '0;
    prod       = '0;
    prod_valid = 1'b0;
    acc_ready  = 1'b0;
    repeat (2) step();
    check("rst_acc", acc_out, 0);
    check("rst_valid", acc_valid, 0);
    check("rst_rdy", prod_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();

    // Cancelling terms, consecutive cycles.
    stim_q = '{64'd1296, -64'sd1296, 64'd1296};
    repeat (3) vpat_q.push_back(1'b1);
    run_job("t1", 3);
    check("t1_exact", acc_out, 64'd1296);
    drain("t1", 3, 1, 1'b0);

    // Empty job.
    stim_q.delete();
    run_job("t2", 0);
    check("t2_zero", acc_out, 0);
    drain("t2", 0, 0, 1'b0);

    // Positive and negative saturation, then continue from the clamp.
    stim_q = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
    run_job("t3p", 2);
    check("t3p_rail", acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
    check("t3p_ovf1", overflow, 1);
    drain("t3p", 2, 0, 1'b0);
    stim_q = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    run_job("t3n", 2);
    check("t3n_rail", acc_out, 64'h8000_0000_0000_0000);
    check("t3n_ovf1", overflow, 1);
    drain("t3n", 2, 0, 1'b0);
    stim_q = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF};
    run_job("t3c", 3);
    check("t3c_from_clamp", acc_out, 64'h7FFF_FFFF_FFFF_FFFE);
    drain("t3c", 3, 0, 1'b0);

    // Gappy valid; result held under backpressure with start pokes ignored.
    stim_q = '{-64'sd1296, -64'sd1296, -64'sd1296, -64'sd1296};
    vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_job("t4", 4);
    check("t4_exact", acc_out, -64'sd5184);
    vpat_q.delete();
    drain("t4", 4, 5, 1'b1);

    // Reset in the middle of a job.
    start = 1'b1;
    len   = CNT_W'(5);
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 64'd77;
    step();
    step();
    prod_valid = 1'b0;
    check("t5_count_pre", count, 2);
    #2 rst = 1'b1;
    #1;
    check("t5_acc", acc_out, 0);
    check("t5_count", count, 0);
    check("t5_busy", busy, 0);
    check("t5_rdy", prod_ready, 0);
    check("t5_valid", acc_valid, 0);
    check("t5_ovf", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check("t5_no_result", acc_valid, 0);
    stim_q = '{64'd0};
    run_job("t5b", 1);
    check("t5b_acc", acc_out, 0);
    check("t5b_ovf", overflow, 0);
    drain("t5b", 1, 0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      stim_q.delete();
      for (int k = 0; k < n; k++) stim_q.push_back(rand_prod());
      run_job("rnd", n);
      drain("rnd", n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
